patternbuf_loader: RTL and testbench

//  Sequencer that fills the serial pattern buffer from a byte stream: takes bytes over a valid/ready

---
 rtl/patternbuf_pkg.sv | 15 +
 rtl/patternbuf_serialiser.sv | 42 ++++
 rtl/patternbuf_loader.sv | 133 +++++++++++++
 tb/tb_patternbuf_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patternbuf_pkg.sv
// Shared types and default geometry for the pattern buffer loader and its serialiser.
package patternbuf_pkg;

  localparam int BUFFER_WIDTH_DEF = 8;
  localparam int BUFFER_SIZE_DEF  = 32;
  localparam int BIT_IDX_W        = $clog2(BUFFER_WIDTH_DEF);
  localparam int BYTE_CNT_W       = $clog2(BUFFER_SIZE_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/patternbuf_serialiser.sv
// Per-byte MSB-first shifter: holds the byte in flight, its bit index and a valid flag.
module patternbuf_serialiser #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             msb,
  output logic             have,
  output logic             last_bit
);

  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] bit_idx;

  // A load on the final shift replaces the outgoing byte, giving seamless back-to-back bytes.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg   <= '0;
      bit_idx <= '0;
      have    <= 1'b0;
    end else if (load) begin
      shreg   <= load_data;
      bit_idx <= '0;
      have    <= 1'b1;
    end else if (shift) begin
      shreg   <= {shreg[WIDTH-2:0], 1'b0};
      bit_idx <= bit_idx + 1'b1;
      if (last_bit) begin
        have <= 1'b0;
      end
    end
  end

  assign msb      = shreg[WIDTH-1];
  assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/patternbuf_loader.sv
// Fills the serial pattern buffer from a valid/ready byte stream, MSB first.
// Optional readback of the displaced contents is enabled by defining PATBUF_READBACK_EN.
module patternbuf_loader
  import patternbuf_pkg::*;
#(
  parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
  parameter int BUFFER_SIZE  = BUFFER_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [BUFFER_WIDTH-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic                    busy,
  output logic                    done,
  output logic [BUFFER_WIDTH-1:0] rd_data,
  output logic                    rd_valid
);

  // Package widths apply to the default geometry; other sizes derive their own.
  localparam int IDX_W = (BUFFER_WIDTH == BUFFER_WIDTH_DEF) ? BIT_IDX_W : $clog2(BUFFER_WIDTH);
  localparam int CNT_W = (BUFFER_SIZE == BUFFER_SIZE_DEF) ? BYTE_CNT_W : $clog2(BUFFER_SIZE + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic             have;
  logic             last_bit;
  logic             msb;
  logic             accept;
  logic             clear;
  logic             shifting;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    shifting   = (state == SHIFT);
    ssel       = 1'b0;
    wr_ready   = 1'b0;
    accept     = 1'b0;
    busy       = shifting;
    done       = (state == DONE);
    sin        = msb;
    clear      = !shifting || abort;
    if (shifting && !abort) begin
      ssel     = have;
      wr_ready = (byte_cnt < CNT_W'(BUFFER_SIZE)) && (!have || last_bit);
      accept   = wr_valid && wr_ready;
    end
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (ssel && last_bit && (byte_cnt == CNT_W'(BUFFER_SIZE))) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  patternbuf_serialiser #(
    .WIDTH (BUFFER_WIDTH),
    .IDX_W (IDX_W)
  ) u_serialiser (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (accept),
    .load_data (wr_data),
    .shift     (ssel),
    .msb       (msb),
    .have      (have),
    .last_bit  (last_bit)
  );

`ifdef PATBUF_READBACK_EN
  // Outgoing bits share the serialiser's bit index, so byte boundaries line up with the writes.
  logic [BUFFER_WIDTH-2:0] rd_shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_shreg <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (ssel) begin
        rd_shreg <= {rd_shreg[BUFFER_WIDTH-3:0], sout};
        if (last_bit) begin
          rd_data  <= {rd_shreg, sout};
          rd_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_sout;

  assign unused_sout = sout;
  assign rd_data     = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_patternbuf_loader.sv
// Scoreboard bench for patternbuf_loader driving a behavioural serial pattern buffer.
// Readback checks are compiled in when PATBUF_READBACK_EN is defined.
module tb_patternbuf_loader;

  localparam int W   = 8;
  localparam int N   = 32;
  localparam int TOT = W * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         ssel;
  logic         sin;
  logic         sout;
  logic         busy;
  logic         done;
  logic [W-1:0] rd_data;
  logic         rd_valid;

  logic [TOT-1:0] chain = '0;
  logic [W-1:0]   src [N];
  logic [W-1:0]   sb_q [$];
  logic [W-1:0]   acc;
  int             acc_bits;
  int             checks = 0;
  int             errors = 0;
  int             ssel_total = 0;
  int             done_total = 0;
`ifdef PATBUF_READBACK_EN
  logic [W-1:0]   rd_q [$];
  int             rd_total = 0;
`endif

  always #5 clk = ~clk;

  // Behavioural patternbuf: one long shift chain, pattern[k] = chain[k*W +: W].
  always @(posedge clk) begin
    if (ssel) begin
      chain <= {chain[TOT-2:0], sin};
    end
  end

  assign sout = chain[TOT-1];

  patternbuf_loader #(
    .BUFFER_WIDTH (W),
    .BUFFER_SIZE  (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .ssel     (ssel),
    .sin      (sin),
    .sout     (sout),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one cycle's inputs and feeds the scoreboard from what the DUT shows before the edge.
  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [W-1:0] d, input logic r);
    start    = s;
    abort    = a;
    wr_valid = v;
    wr_data  = d;
    rst      = r;
    #1;
    if (!r) begin
      if (wr_valid && wr_ready) begin
        sb_q.push_back(wr_data);
      end
      if (ssel) begin
        ssel_total++;
        acc = {acc[W-2:0], sin};
        acc_bits++;
        if (acc_bits == W) begin
          acc_bits = 0;
          checkOutput("sb_has_byte", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            checkOutput("shifted_byte", acc, sb_q.pop_front());
          end
        end
      end
      if (done) begin
        done_total++;
      end
`ifdef PATBUF_READBACK_EN
      if (rd_valid) begin
        rd_total++;
        checkOutput("rd_has_byte", (rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          checkOutput("rd_data", rd_data, rd_q.pop_front());
        end
      end
`endif
    end
  endtask

  task automatic flushModel();
    sb_q.delete();
    acc_bits = 0;
`ifdef PATBUF_READBACK_EN
    rd_q.delete();
`endif
  endtask

  // One load of src[]: optional underrun at byte gap_byte, abort after abort_at shifts,
  // reset once rst_at bytes are in, or start pokes during SHIFT and DONE.
  task automatic doLoad(input int gap_byte, input int gap_len, input int abort_at,
                        input int rst_at, input bit poke);
    int       idx;
    int       cyc;
    int       gap_left;
    int       gap_pos;
    int       ssel0;
    int       done0;
    logic     s;
    logic     a;
    logic     v;
    logic     r;
    bit       ingap;
    bit       fin;
    logic [W-1:0] d;
`ifdef PATBUF_READBACK_EN
    int       rd0;
`endif
    idx      = 0;
    cyc      = 0;
    gap_left = gap_len;
    gap_pos  = 0;
    fin      = 1'b0;
    ssel0    = ssel_total;
    done0    = done_total;
    flushModel();
`ifdef PATBUF_READBACK_EN
    rd0 = rd_total;
    for (int k = N - 1; k >= 0; k--) begin
      rd_q.push_back(chain[k*W +: W]);
    end
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("busy_in_start_cycle", busy, 0);
    nextCycle();
    while (!fin && cyc < 1000) begin
      cyc++;
      a = (abort_at >= 0) && (ssel_total - ssel0 == abort_at);
      s = poke && ((cyc == 40) || (ssel_total - ssel0 == TOT));
      r = (rst_at >= 0) && (idx == rst_at);
      v = (idx < N);
      d = (idx < N) ? src[idx] : '0;
      ingap = 1'b0;
      if ((gap_byte >= 0) && (idx == gap_byte) && (gap_left > 0) && wr_ready) begin
        v     = 1'b0;
        ingap = 1'b1;
      end
      applyStimulus(s, a, v, d, r);
      if (cyc == 1) begin
        checkOutput("busy_after_start", busy, 1);
      end
      if (r) begin
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        checkOutput("rst_ssel", ssel, 0);
        checkOutput("rst_sin", sin, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        nextCycle();
        flushModel();
        return;
      end
      if (ingap) begin
        checkOutput("underrun_ssel", ssel, (gap_pos == 0));
        gap_pos++;
        gap_left--;
      end
      if (a) begin
        checkOutput("abort_ssel", ssel, 0);
        checkOutput("abort_wr_ready", wr_ready, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("abort_idle_busy", busy, 0);
        checkOutput("abort_idle_wr_ready", wr_ready, 0);
        nextCycle();
        for (int i = 0; i < 10; i++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
          nextCycle();
        end
        checkOutput("abort_no_done", done_total - done0, 0);
        flushModel();
        return;
      end
      if (done) begin
        fin = 1'b1;
        checkOutput("ssel_count", ssel_total - ssel0, TOT);
        checkOutput("done_busy", busy, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("done_width", done, 0);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("done_count", done_total - done0, 1);
        checkOutput("sb_drained", sb_q.size(), 0);
`ifdef PATBUF_READBACK_EN
        checkOutput("rd_count", rd_total - rd0, N);
        checkOutput("rd_drained", rd_q.size(), 0);
`else
        checkOutput("rd_valid_off", rd_valid, 0);
`endif
      end
      if ((idx < N) && wr_valid && wr_ready) begin
        idx++;
      end
      nextCycle();
    end
    checkOutput("load_completed", fin, 1);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("pattern[%0d]", k), chain[k*W +: W], src[N-1-k]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    acc      = '0;
    acc_bits = 0;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("reset_ssel", ssel, 0);
    checkOutput("reset_sin", sin, 0);
    checkOutput("reset_wr_ready", wr_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    nextCycle();

    $display("[TB] full load 0x00..0x1F");
    for (int i = 0; i < N; i++) src[i] = W'(i);
    doLoad(-1, 0, -1, -1, 1'b0);

    $display("[TB] underrun after byte 3");
    for (int i = 0; i < N; i++) src[i] = W'(8'hC0 + i);
    doLoad(4, 5, -1, -1, 1'b0);

    $display("[TB] abort after 100 shifts, then 0xA5 load");
    for (int i = 0; i < N; i++) src[i] = W'(8'h33 * i);
    doLoad(-1, 0, 100, -1, 1'b0);
    for (int i = 0; i < N; i++) src[i] = 8'hA5;
    doLoad(-1, 0, -1, -1, 1'b0);

    $display("[TB] start pulsed in SHIFT and DONE");
    for (int i = 0; i < N; i++) src[i] = W'(8'h3C ^ (7 * i));
    doLoad(-1, 0, -1, -1, 1'b1);

    $display("[TB] reset at byte 10, then a fresh load");
    for (int i = 0; i < N; i++) src[i] = W'(8'h11 * i);
    doLoad(-1, 0, -1, 10, 1'b0);
    for (int i = 0; i < N; i++) src[i] = W'(~i);
    doLoad(-1, 0, -1, -1, 1'b0);

`ifdef PATBUF_READBACK_EN
    $display("[TB] readback swap");
    for (int i = 0; i < N; i++) src[i] = W'(i);
    doLoad(-1, 0, -1, -1, 1'b0);
    for (int i = 0; i < N; i++) src[i] = 8'hFF;
    doLoad(-1, 0, -1, -1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
